// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding select and load-use stall unit with stall counter
module fwd_hazard_unit #(
    parameter  int NUM_SRC    = 2,
    parameter  int FWD_DEPTH  = 3,
    parameter  int REG_AW     = 5,
    parameter  int LOAD_READY = 1,
    parameter  int CNT_W      = 32,
    localparam int SELW       = $clog2(FWD_DEPTH + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] i_id_rs,
    input  logic [NUM_SRC-1:0]        i_id_rs_used,
    input  logic [REG_AW-1:0]         i_id_rd,
    input  logic                      i_id_reg_write,
    input  logic                      i_id_is_load,
    input  logic                      i_hold,
    input  logic                      i_flush,
    input  logic                      i_stat_clr,
    output logic [NUM_SRC*SELW-1:0]   o_fwd_sel,
    output logic                      o_stall,
    output logic [CNT_W-1:0]          o_stall_cnt
);

    generate
        if (FWD_DEPTH < 1 || LOAD_READY > FWD_DEPTH) begin : g_bad_params
            $fatal(1, "fwd_hazard_unit: need FWD_DEPTH >= 1 and LOAD_READY <= FWD_DEPTH");
        end
    endgenerate

    // Entry 0 is EX, higher indices are progressively older stages.
    logic [FWD_DEPTH-1:0] r_valid;
    logic [FWD_DEPTH-1:0] r_wr;
    logic [FWD_DEPTH-1:0] r_load;
    logic [REG_AW-1:0]    r_rd [FWD_DEPTH];
    logic [CNT_W-1:0]     r_cnt;

    logic [SELW-1:0]      w_sel_raw [NUM_SRC];
    logic [NUM_SRC-1:0]   w_hazard;
    logic                 w_stall;
    logic                 w_issue;

    always_comb begin
        w_hazard = '0;
        for (int j = 0; j < NUM_SRC; j++) begin : g_src
            logic [REG_AW-1:0] v_rs;
            logic              v_found;
            v_rs         = i_id_rs[j*REG_AW +: REG_AW];
            v_found      = 1'b0;
            w_sel_raw[j] = '0;
            // Scan from youngest so the first hit shadows any older writer.
            for (int k = 0; k < FWD_DEPTH; k++) begin
                if (!v_found && i_id_rs_used[j] && (v_rs != '0) &&
                    r_valid[k] && r_wr[k] && (r_rd[k] == v_rs)) begin
                    v_found      = 1'b1;
                    w_sel_raw[j] = SELW'(k + 1);
                    w_hazard[j]  = r_load[k] && (k < LOAD_READY);
                end
            end
        end
    end

    assign w_stall = i_id_valid && !i_flush && (|w_hazard);
    assign w_issue = i_id_valid && !w_stall && !i_flush;

    always_comb begin
        o_fwd_sel = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            if (i_id_valid && !w_stall) begin
                o_fwd_sel[j*SELW +: SELW] = w_sel_raw[j];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= '0;
            r_wr    <= '0;
            r_load  <= '0;
            r_cnt   <= '0;
            for (int k = 0; k < FWD_DEPTH; k++) begin
                r_rd[k] <= '0;
            end
        end else begin
            if (!i_hold) begin
                for (int k = 1; k < FWD_DEPTH; k++) begin
                    r_valid[k] <= r_valid[k-1];
                    r_wr[k]    <= r_wr[k-1];
                    r_load[k]  <= r_load[k-1];
                    r_rd[k]    <= r_rd[k-1];
                end
                // x0 writes are dropped here so they can never be forwarded.
                r_valid[0] <= w_issue;
                r_wr[0]    <= w_issue && i_id_reg_write && (i_id_rd != '0);
                r_load[0]  <= w_issue && i_id_is_load;
                r_rd[0]    <= i_id_rd;
            end
            if (i_stat_clr) begin
                r_cnt <= '0;
            end else if (!i_hold && w_stall && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_stall     = w_stall;
    assign o_stall_cnt = r_cnt;

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised forwarding and load-use hazard unit for the in-order RV32 pipeline. It tracks in-flight register writes in an internal shift register of FWD_DEPTH entries. Entry 0 is EX, entry 1 is MEM, entry 2 is WB. For every source operand of the instruction in ID it produces a forward select, and it raises a load-use stall when the required data is not yet forwardable. It also keeps a saturating stall-cycle counter for performance statistics.

Parameters:
NUM_SRC, 2, number of source operands checked per instruction (rs1, rs2; 3 for future R4 ops).
FWD_DEPTH, 3, number of tracked downstream stages (entries 0..FWD_DEPTH-1); must be ≥1.
REG_AW, 5, register address width.
LOAD_READY, 1, lowest entry index from which a load result is forwardable.
CNT_W, 32, width of the stall counter.
Derived: SELW = $clog2(FWD_DEPTH+1).

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous, active-high reset
i_id_valid  in  1  valid instruction in ID
i_id_rs  in  NUM_SRC*REG_AW  packed source addresses; src j is bits [j*REG_AW +: REG_AW]
i_id_rs_used  in  NUM_SRC  per-source "operand actually read" mask
i_id_rd  in  REG_AW  destination of ID instruction
i_id_reg_write  in  1  ID instruction writes rd
i_id_is_load  in  1  ID instruction is a load
i_hold  in  1  whole-pipeline freeze (e.g. memory wait)
i_flush  in  1  kill the ID instruction (branch/jump redirect)
i_stat_clr  in  1  synchronous clear of stall counter
o_fwd_sel  out  NUM_SRC*SELW  per-source select: 0 = register file, k+1 = entry k
o_stall  out  1  load-use stall request to IF/ID
o_stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Entry fields: valid, rd, wr, is_load. A stored wr is i_id_reg_write && (i_id_rd != 0), so x0 is never tracked.
- Reset (async, i_rst=1): all entries invalid, o_stall_cnt=0. o_fwd_sel=0 and o_stall=0 follow combinationally.
- Match for src j at entry k: i_id_rs_used[j], rs_j != 0, entry k valid && wr, rd == rs_j.
- Youngest (lowest k) match wins. Older matches are ignored.
- Hazard for src j: the winning entry has is_load=1 and k < LOAD_READY.
- o_stall = i_id_valid && !i_flush && (any src hazard). Combinational, same cycle.
- o_fwd_sel[j] = k+1 for a winning match, else 0. It is forced to 0 for all j when o_stall=1 or i_id_valid=0.
- o_fwd_sel names entries as of the ID cycle. The datapath registers the selects into ID/EX.
- Update on each rising edge when i_hold=0:
  - entry[k] <= entry[k-1] for k = 1..FWD_DEPTH-1.
  - entry[0] <= ID instruction fields if i_id_valid && !o_stall && !i_flush, else bubble (valid=0).
  - The oldest entry falls off.
- i_hold=1: all entries frozen, counter frozen. Outputs are still computed from the frozen state.
- i_flush and a hazard in the same cycle: flush wins. o_stall=0 and a bubble is inserted.
- Counter update (when i_hold=0):
  - i_stat_clr=1 → 0 (priority over increment).
  - Else if o_stall → +1, saturating at 2^CNT_W-1 (no wrap).
  - With i_hold=1, i_stat_clr still clears.
- Combinational outputs have no registered latency. Stall-to-release latency is (LOAD_READY - k) cycles for a load at entry k.
- Elaboration check: FWD_DEPTH ≥ 1 and LOAD_READY ≤ FWD_DEPTH. Violations are a fatal error at elaboration.

Test Plan:
- Defaults. Issue `addi x5` then `add x6,x5,x7` (rs used 11): cycle 2 → o_fwd_sel src0=1 (EX), src1=0, o_stall=0. One bubble gap → src0=2. Two bubble gap → src0=3. Three bubble gap → 0.
- Issue `lw x5`, then `add x6,x5,x5`: o_stall=1 for exactly 1 cycle, sel=0 while stalled, bubble enters EX. Next cycle sel src0=src1=2, o_stall=0, o_stall_cnt=1.
- Two writers to x5 back to back (`addi x5`, `addi x5`), then a consumer of x5 → sel=1 (youngest). A writer to x0 followed by a reader of x0 → sel=0, no stall.
- Load to x5 followed by consumer with i_flush=1 in the stall cycle → o_stall=0, bubble inserted, o_stall_cnt unchanged. Consumer with i_id_rs_used=00 after a load → no stall.
- Load-use stall with i_hold=1 for 4 cycles → entries frozen, o_stall stays 1, counter unchanged. After hold drops, the stall resolves after 1 cycle.
- Counter: CNT_W=4, force 20 stall cycles → o_stall_cnt saturates at 15. Assert i_stat_clr → 0 on next edge. Assert i_rst mid-stall → o_stall_cnt=0 and all selects 0 immediately, no clock edge needed.
